// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: FETCH -> ISSUE -> EXEC per instruction, HALT on HLT.
// Define IF_ACK_TIMEOUT_EN to enable the mem_ack read timeout (bus_err).
module instr_fetch #(
  parameter int PC_W    = 5,
  parameter int ACK_TMO = 15
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_rd,
  output logic [PC_W-1:0] mem_addr,
  input  logic [7:0]      mem_rdata,
  input  logic            mem_ack,
  input  logic            zero,
  output logic [7:0]      ir_data,
  output logic            ir_valid,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            bus_err
);

  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_EXEC, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_nxt, jmp_tgt;
  logic [PC_W-1:0] mem_addr_q, mem_addr_d;
  logic            mem_rd_q, mem_rd_d;
  logic [7:0]      ir_data_q, ir_data_d;
  logic            ir_valid_q, ir_valid_d;
  logic            halted_q, halted_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [2:0]      opcode;
  logic            tmo;

  assign opcode  = ir_data_q[7:5];
  assign jmp_tgt = PC_W'(ir_data_q[4:0]);

  // Only an ack against a request actually on the bus counts as a capture.
  logic ack_take;
  assign ack_take = (state_q == S_FETCH) && mem_rd_q && mem_ack;

`ifdef IF_ACK_TIMEOUT_EN
  localparam int WC_W = $clog2(ACK_TMO + 1);
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic            bus_err_q, bus_err_d;

  assign tmo = (state_q == S_FETCH) && mem_rd_q && !mem_ack &&
               (wcnt_q == WC_W'(ACK_TMO - 1));

  always_comb begin
    wcnt_d    = wcnt_q;
    bus_err_d = bus_err_q | tmo;
    if (state_d == S_FETCH && state_q != S_FETCH)
      wcnt_d = '0;
    else if (state_q == S_FETCH && mem_rd_q && !mem_ack)
      wcnt_d = wcnt_q + WC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

  // Zero is looked at only here, which is consulted only on the last EXEC cycle.
  always_comb begin
    if (opcode == 3'b111)
      pc_nxt = jmp_tgt;
    else if (opcode == 3'b001 && zero)
      pc_nxt = pc_q + PC_W'(2);
    else
      pc_nxt = pc_q + PC_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    ir_data_d  = ir_data_q;
    ir_valid_d = 1'b0;
    halted_d   = halted_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      S_FETCH: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = pc_q;
        if (ack_take) begin
          ir_data_d  = mem_rdata;
          mem_rd_d   = 1'b0;
          ir_valid_d = 1'b1;
          state_d    = S_ISSUE;
        end else if (tmo) begin
          mem_rd_d = 1'b0;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end
      end
      S_ISSUE: begin
        unique case (opcode)
          3'b010, 3'b011, 3'b100, 3'b101: cnt_d = 3'd5;
          3'b110:                         cnt_d = 3'd4;
          default:                        cnt_d = 3'd3;
        endcase
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (opcode == 3'b000) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            // Request goes out on the same edge the PC moves.
            pc_d       = pc_nxt;
            mem_addr_d = pc_nxt;
            mem_rd_d   = 1'b1;
            state_d    = S_FETCH;
          end
        end
      end
      S_HALT: begin
        mem_rd_d = 1'b0;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      ir_data_q  <= 8'h00;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      ir_data_q  <= ir_data_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign ir_data  = ir_data_q;
  assign ir_valid = ir_valid_q;
  assign pc       = pc_q;
  assign halted   = halted_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 5, meaning the program counter and memory address width in bits.
REQ-002 SHALL have parameter ACK_TMO, default 15, meaning the maximum number of cycles to wait for mem_ack (used only with REQ-026).
REQ-003 SHALL have these ports, clock and reset first:
 - clk  input  1  single clock; all state changes on its rising edge.
 - rst  input  1  asynchronous, active-high reset.
 - mem_rd  output  1  instruction-memory read request.
 - mem_addr  output  PC_W  instruction-memory read address.
 - mem_rdata  input  8  instruction byte returned by memory.
 - mem_ack  input  1  memory read completion; mem_rdata is valid in the same cycle.
 - zero  input  1  accumulator-zero flag, sampled for SKZ.
 - ir_data  output  8  instruction byte presented to the instruction register.
 - ir_valid  output  1  one-cycle strobe marking a new ir_data.
 - pc  output  PC_W  current program counter.
 - halted  output  1  fetch stopped by HLT (or by bus error).
 - bus_err  output  1  read timeout flag (REQ-026).

Function
REQ-004 SHALL implement the states FETCH, ISSUE, EXEC and HALT.
REQ-005 In FETCH: SHALL assert mem_rd=1 and drive mem_addr=pc, holding both stable until mem_ack=1.
REQ-006 On FETCH with mem_ack=1: SHALL capture mem_rdata into ir_data, deassert mem_rd in the next cycle, and go to ISSUE.
REQ-007 In ISSUE: SHALL assert ir_valid=1 for exactly one cycle, with ir_data held stable from that cycle until the next capture.
REQ-008 In ISSUE: SHALL load the execute counter from opcode ir_data[7:5] as follows: 010, 011, 100 and 101 load 5; 110 loads 4; all other opcodes load 3. It then goes to EXEC.
REQ-009 In EXEC: SHALL decrement the counter once per cycle and leave EXEC in the cycle the counter reads 1. The next ir_valid therefore occurs no sooner than count+1 cycles after the previous one.
REQ-010 On leaving EXEC, the PC SHALL be updated as follows:
 - opcode 111 (JMP): pc <= ir_data[4:0].
 - opcode 001 (SKZ) with zero=1: pc <= pc+2.
 - otherwise: pc <= pc+1.
REQ-011 The zero flag SHALL be sampled only in the last EXEC cycle.
REQ-012 PC arithmetic SHALL be modulo 2^PC_W. Wrap-around examples: 31+1 -> 0, 31+2 -> 1, 30+2 -> 0.
REQ-013 On leaving EXEC with opcode 000 (HLT): the PC SHALL NOT change, the block SHALL go to HALT, and halted SHALL be set to 1.
REQ-014 For any opcode other than HLT, leaving EXEC SHALL return to FETCH.
REQ-015 HALT SHALL be absorbing: mem_rd=0 and ir_valid=0 until rst.
REQ-016 mem_ack SHALL be ignored outside FETCH; a stray ack SHALL NOT change any state.
REQ-017 ir_valid and mem_rd SHALL never both be 1 in the same cycle.
REQ-018 All outputs SHALL be driven from registers, with no combinational path from any input to any output.

Reset
REQ-019 While rst=1, the outputs SHALL be held at these values: pc=0, mem_addr=0, mem_rd=0, ir_data=8'h00, ir_valid=0, halted=0, bus_err=0, and the execute counter SHALL be 0.
REQ-020 After rst deasserts, the state SHALL be FETCH, and mem_rd SHALL assert at the first rising edge of clk.
REQ-021 rst asserted in any state, including mid-FETCH with mem_rd=1 or mid-EXEC, SHALL abort immediately with no PC update.
REQ-022 rst SHALL be the only exit from HALT.

Configuration
REQ-023 Macro IF_ACK_TIMEOUT_EN SHALL select the read-timeout feature.
REQ-024 With IF_ACK_TIMEOUT_EN undefined: FETCH SHALL wait indefinitely for mem_ack, and bus_err SHALL be tied to 0.
REQ-025 With IF_ACK_TIMEOUT_EN defined: a wait counter SHALL clear on entry to FETCH and increment on each cycle of FETCH in which mem_ack=0.
REQ-026 With IF_ACK_TIMEOUT_EN defined and the wait counter reaching ACK_TMO: the block SHALL set bus_err=1 (sticky until rst), deassert mem_rd, go to HALT and set halted=1, without issuing ir_valid.
REQ-027 With IF_ACK_TIMEOUT_EN defined: mem_ack=1 in the same cycle the wait counter reaches ACK_TMO SHALL win, giving a normal capture with no error.

Verification
REQ-028 Reset, memory with 1-cycle ack, byte 8'h41 (ADD) at address 0 -> mem_addr=0, ir_valid pulses with ir_data=8'h41, the next mem_rd asserts 6 cycles after the ir_valid, and pc=1.
REQ-029 Byte 8'hE7 (JMP 7) at pc=3 -> the next fetch has mem_addr=7.
REQ-030 Byte 8'h20 (SKZ) at pc=4:
 - zero=1 in the last EXEC cycle -> the next fetch is at address 6.
 - zero=0 -> the next fetch is at address 5.
REQ-031 Byte 8'hC0 (STO) at pc=31 -> the next fetch is at address 0. Then byte 8'h00 (HLT) -> halted=1, pc=0, mem_rd stays 0 for 50 cycles, and pulsing rst restarts fetching at address 0.
REQ-032 rst asserted while mem_rd=1 and ack is pending -> mem_rd=0 the same cycle, and a later mem_ack produces no ir_valid.
REQ-033 With IF_ACK_TIMEOUT_EN defined and mem_ack never asserted -> bus_err=1 and halted=1 after 15 FETCH cycles, with no ir_valid. With ack at exactly cycle 15 -> normal capture and bus_err=0.
